// File: rtl/ifmap_spad_write_controller.sv
// Write-side controller for the PE ifmap scratchpad (circular buffer).
// Accepts the row stream, tracks occupancy and exposes the read window base.
module ifmap_spad_write_controller #(
  parameter int IFMAP_SPAD_DEPTH         = 12,
  parameter int IFMAP_SPAD_ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH               = 8,
  parameter int CONFIG_BIT               = 5
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                clear,
  input  logic                                start,
  input  logic [CONFIG_BIT-1:0]               ifmap_size,
  input  logic [CONFIG_BIT-1:0]               filter_size,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                in_ready,
  input  logic                                free_en,
  output logic                                spad_wen,
  output logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] spad_waddr,
  output logic [DATA_WIDTH-1:0]               spad_wdata,
  output logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] base_address,
  output logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] occupancy,
  output logic                                window_ready,
  output logic                                row_done,
  output logic                                underflow_err
);

  localparam int AW = IFMAP_SPAD_ADDRESS_WIDTH;
  localparam logic [AW-1:0] DEPTH = AW'(IFMAP_SPAD_DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(IFMAP_SPAD_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t              state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       occ;
  logic [CONFIG_BIT-1:0] wr_cnt;
  logic                row_done_q;
  logic                underflow_q;

  logic                accept;
  logic                free_ok;
  logic [CONFIG_BIT:0] wr_cnt_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready   = (state == RECV) && (occ < DEPTH) && (wr_cnt < ifmap_size);
  assign accept     = in_valid && in_ready;
  assign free_ok    = free_en && (occ != '0);
  assign wr_cnt_nxt = {1'b0, wr_cnt} + 1'b1;

  // Write data is gated by the accept so every output reads 0 while held in reset.
  assign spad_wen      = accept;
  assign spad_waddr    = wr_ptr;
  assign spad_wdata    = accept ? in_data : '0;
  assign base_address  = rd_ptr;
  assign occupancy     = occ;
  assign window_ready  = (state != IDLE) && (occ >= AW'(filter_size));
  assign row_done      = row_done_q;
  assign underflow_err = underflow_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      wr_cnt      <= '0;
      row_done_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      wr_cnt      <= '0;
      row_done_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      row_done_q <= 1'b0;

      if (accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
        wr_cnt <= wr_cnt_nxt[CONFIG_BIT-1:0];
      end

      if (free_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end else if (free_en) begin
        underflow_q <= 1'b1;
      end

      case ({accept, free_ok})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase

      case (state)
        IDLE: begin
          wr_cnt <= '0;
          if (start && (ifmap_size != '0)) state <= RECV;
        end
        RECV: begin
          if (accept && (wr_cnt_nxt >= {1'b0, ifmap_size})) state <= DRAIN;
        end
        DRAIN: begin
          if (occ == '0) begin
            state      <= IDLE;
            row_done_q <= 1'b1;
            wr_cnt     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_spad_write_controller.sv
// Scoreboard bench for ifmap_spad_write_controller: expected writes are queued
// by the stimulus and popped by a monitor on every spad_wen.
module tb_ifmap_spad_write_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clear;
  logic        start;
  logic [4:0]  ifmap_size;
  logic [4:0]  filter_size;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        free_en;
  logic        spad_wen;
  logic [15:0] spad_waddr;
  logic [7:0]  spad_wdata;
  logic [15:0] base_address;
  logic [15:0] occupancy;
  logic        window_ready;
  logic        row_done;
  logic        underflow_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  ifmap_spad_write_controller #(
    .IFMAP_SPAD_DEPTH(12),
    .IFMAP_SPAD_ADDRESS_WIDTH(16),
    .DATA_WIDTH(8),
    .CONFIG_BIT(5)
  ) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .start(start),
    .ifmap_size(ifmap_size), .filter_size(filter_size),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .free_en(free_en), .spad_wen(spad_wen), .spad_waddr(spad_waddr),
    .spad_wdata(spad_wdata), .base_address(base_address),
    .occupancy(occupancy), .window_ready(window_ready),
    .row_done(row_done), .underflow_err(underflow_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic apply_reset();
    rstn = 1'b0; clear = 1'b0; start = 1'b0; ifmap_size = '0; filter_size = '0;
    in_valid = 1'b0; in_data = '0; free_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (spad_wen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(spad_waddr), 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(spad_waddr), 32'(w.addr));
        check("wr_data", 32'(spad_wdata), 32'(w.data));
      end
    end
  end

  initial begin
    logic [15:0] pat;
    int unsigned n;

    // Reset state
    apply_reset();
    rstn = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wen", spad_wen, 0);
    check("rst_waddr", spad_waddr, 0);
    check("rst_base", base_address, 0);
    check("rst_occ", occupancy, 0);
    check("rst_window", window_ready, 0);
    check("rst_row_done", row_done, 0);
    check("rst_underflow", underflow_err, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic row: 5 words, window of 3
    for (int unsigned i = 0; i < 5; i++) push(16'(i), 8'(8'hA0 + i));
    step();
    start = 1'b1; ifmap_size = 5'd5; filter_size = 5'd3; in_valid = 1'b1; in_data = 8'hA0;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      in_data = 8'(8'hA0 + i);
      sample();
      check("basic_in_ready", in_ready, 1);
      check("basic_occ", occupancy, i);
      check("basic_window", window_ready, (i >= 3) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    sample();
    check("drain_in_ready", in_ready, 0);
    check("drain_occ", occupancy, 5);
    check("drain_window", window_ready, 1);
    for (int unsigned k = 1; k <= 5; k++) begin
      step();
      free_en = 1'b1;
      step();
      free_en = 1'b0;
      sample();
      check("free_base", base_address, k);
      check("free_occ", occupancy, 5 - k);
      check("free_no_row_done", row_done, 0);
    end
    step();
    sample();
    check("row_done_pulse", row_done, 1);
    check("idle_window", window_ready, 0);
    step();
    sample();
    check("row_done_once", row_done, 0);

    // Full stall and wrap
    apply_reset();
    for (int unsigned i = 0; i < 12; i++) push(16'(i), 8'(8'h10 + i));
    push(16'd0, 8'h1C);
    step();
    start = 1'b1; ifmap_size = 5'd20; filter_size = 5'd3; in_valid = 1'b1; in_data = 8'h10;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      in_data = 8'(8'h10 + i);
      sample();
      check("fill_in_ready", in_ready, 1);
      step();
    end
    in_data = 8'h1C;
    sample();
    check("full_in_ready", in_ready, 0);
    check("full_occ", occupancy, 12);
    step();
    free_en = 1'b1;
    sample();
    check("full_free_in_ready", in_ready, 0);
    step();
    free_en = 1'b0;
    sample();
    check("after_free_in_ready", in_ready, 1);
    check("after_free_occ", occupancy, 11);
    check("after_free_base", base_address, 1);
    step();
    in_valid = 1'b0;
    sample();
    check("refill_occ", occupancy, 12);

    // Simultaneous accept and free at occupancy 4
    apply_reset();
    for (int unsigned i = 0; i < 6; i++) push(16'(i), 8'(8'h30 + i));
    step();
    start = 1'b1; ifmap_size = 5'd10; filter_size = 5'd3; in_valid = 1'b1; in_data = 8'h30;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_data = 8'(8'h30 + i);
      sample();
      step();
    end
    in_data = 8'h34;
    free_en = 1'b1;
    sample();
    check("sim_occ_before", occupancy, 4);
    check("sim_in_ready", in_ready, 1);
    step();
    free_en = 1'b0;
    in_valid = 1'b0;
    sample();
    check("sim_occ_after", occupancy, 4);
    check("sim_base", base_address, 1);
    check("sim_wr_ptr", spad_waddr, 5);
    step();
    in_valid = 1'b1; in_data = 8'h35;
    sample();
    step();
    in_valid = 1'b0;
    sample();
    check("sim_occ_final", occupancy, 5);

    // Underflow in IDLE
    apply_reset();
    step();
    sample();
    check("uf_initial", underflow_err, 0);
    step();
    free_en = 1'b1;
    step();
    free_en = 1'b0;
    sample();
    check("uf_set", underflow_err, 1);
    check("uf_base", base_address, 0);
    check("uf_occ", occupancy, 0);
    repeat (3) step();
    sample();
    check("uf_sticky", underflow_err, 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sample();
    check("uf_cleared", underflow_err, 0);

    // Backpressure: irregular in_valid over a 5-word row
    apply_reset();
    for (int unsigned i = 0; i < 5; i++) push(16'(i), 8'(8'h50 + i));
    step();
    start = 1'b1; ifmap_size = 5'd5; filter_size = 5'd2; in_valid = 1'b0;
    step();
    start = 1'b0;
    pat = 16'b0110_1001_1100_1011;
    n = 0;
    for (int unsigned c = 0; c < 40 && n < 5; c++) begin
      in_valid = pat[c % 16];
      in_data  = 8'(8'h50 + n);
      sample();
      check("bp_in_ready", in_ready, 1);
      if (in_valid) n++;
      step();
    end
    check("bp_words", n, 5);
    in_valid = 1'b0;
    sample();
    check("bp_done_in_ready", in_ready, 0);
    check("bp_occ", occupancy, 5);

    // Synchronous clear mid-row at occupancy 3
    apply_reset();
    for (int unsigned i = 0; i < 3; i++) push(16'(i), 8'(8'h70 + i));
    for (int unsigned i = 0; i < 3; i++) push(16'(i), 8'(8'h80 + i));
    step();
    start = 1'b1; ifmap_size = 5'd8; filter_size = 5'd3; in_valid = 1'b1; in_data = 8'h70;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      in_data = 8'(8'h70 + i);
      sample();
      step();
    end
    in_valid = 1'b0;
    sample();
    check("clr_occ_before", occupancy, 3);
    check("clr_window_before", window_ready, 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    sample();
    check("clr_in_ready", in_ready, 0);
    check("clr_occ", occupancy, 0);
    check("clr_base", base_address, 0);
    check("clr_waddr", spad_waddr, 0);
    check("clr_window", window_ready, 0);
    check("clr_row_done", row_done, 0);
    step();
    sample();
    check("clr_no_row_done", row_done, 0);

    // Asynchronous reset mid-row
    step();
    start = 1'b1; in_valid = 1'b1; in_data = 8'h80;
    step();
    start = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      in_data = 8'(8'h80 + i);
      sample();
      step();
    end
    in_valid = 1'b0;
    sample();
    check("arst_occ_before", occupancy, 3);
    step();
    #2;
    rstn = 1'b0;
    #1;
    check("arst_occ", occupancy, 0);
    check("arst_waddr", spad_waddr, 0);
    check("arst_base", base_address, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_window", window_ready, 0);
    check("arst_wen", spad_wen, 0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
